// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants for the frame reader and its timing generator.
package vga_pkg;

    localparam int unsigned H_VISIBLE  = 640;
    localparam int unsigned H_FP_END   = 656;
    localparam int unsigned H_SYNC_END = 752;
    localparam int unsigned H_TOTAL    = 800;

    localparam int unsigned V_VISIBLE  = 480;
    localparam int unsigned V_FP_END   = 490;
    localparam int unsigned V_SYNC_END = 492;
    localparam int unsigned V_TOTAL    = 525;

    // Wide enough for both the 0..799 and 0..524 scan counters.
    localparam int unsigned CNT_W = 10;

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable phase, h/v scan counters and registered decodes of the current scan position.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned T_H_VISIBLE  = H_VISIBLE,
    parameter int unsigned T_H_FP_END   = H_FP_END,
    parameter int unsigned T_H_SYNC_END = H_SYNC_END,
    parameter int unsigned T_H_TOTAL    = H_TOTAL,
    parameter int unsigned T_V_VISIBLE  = V_VISIBLE,
    parameter int unsigned T_V_FP_END   = V_FP_END,
    parameter int unsigned T_V_SYNC_END = V_SYNC_END,
    parameter int unsigned T_V_TOTAL    = V_TOTAL
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             phase_o,
    output logic             vga_clk_o,
    output logic [CNT_W-1:0] h_o,
    output logic [CNT_W-1:0] v_o,
    output logic             hsync_raw_o,
    output logic             vsync_raw_o,
    output logic             visible_o,
    output logic             frame_start_o
);

    logic             phase_q;
    logic             vga_clk_q;
    logic             hsync_q;
    logic             vsync_q;
    logic             visible_q;
    logic             frame_start_q;
    logic [CNT_W-1:0] h_q;
    logic [CNT_W-1:0] h_d;
    logic [CNT_W-1:0] v_q;
    logic [CNT_W-1:0] v_d;

    // Counters advance on the second clk of each pixel slot.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (phase_q) begin
            if (h_q == CNT_W'(T_H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == CNT_W'(T_V_TOTAL - 1)) ? '0 : v_q + CNT_W'(1);
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end
    end

    // Decodes are computed from next-state so they describe the registered h/v.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q       <= 1'b0;
            vga_clk_q     <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            visible_q     <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            phase_q       <= ~phase_q;
            vga_clk_q     <= phase_q;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= !((h_d >= CNT_W'(T_H_FP_END)) && (h_d < CNT_W'(T_H_SYNC_END)));
            vsync_q       <= !((v_d >= CNT_W'(T_V_FP_END)) && (v_d < CNT_W'(T_V_SYNC_END)));
            visible_q     <= (h_d < CNT_W'(T_H_VISIBLE)) && (v_d < CNT_W'(T_V_VISIBLE));
            frame_start_q <= !phase_q && (h_q == '0) && (v_q == '0);
        end
    end

    assign phase_o       = phase_q;
    assign vga_clk_o     = vga_clk_q;
    assign h_o           = h_q;
    assign v_o           = v_q;
    assign hsync_raw_o   = hsync_q;
    assign vsync_raw_o   = vsync_q;
    assign visible_o     = visible_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: rtl/vga_frame_reader.sv
// Scans a scaled image out of RAM through a one-clk-latency read port and drives VGA rgb/syncs.
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int unsigned S            = 32,
    parameter int unsigned PIX_W        = 24,
    parameter int unsigned IMG_W        = 100,
    parameter int unsigned IMG_H        = 100,
    parameter int unsigned SCALE        = 4,
    parameter int unsigned X0           = 120,
    parameter int unsigned Y0           = 40,
    parameter int unsigned BASE         = 0,
    parameter int unsigned T_H_VISIBLE  = H_VISIBLE,
    parameter int unsigned T_H_FP_END   = H_FP_END,
    parameter int unsigned T_H_SYNC_END = H_SYNC_END,
    parameter int unsigned T_H_TOTAL    = H_TOTAL,
    parameter int unsigned T_V_VISIBLE  = V_VISIBLE,
    parameter int unsigned T_V_FP_END   = V_FP_END,
    parameter int unsigned T_V_SYNC_END = V_SYNC_END,
    parameter int unsigned T_V_TOTAL    = V_TOTAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic             rd_en,
    output logic [S-1:0]     rd_addr,
    input  logic [PIX_W-1:0] rd_data,
    output logic [PIX_W-1:0] rgb,
    output logic             h_sync,
    output logic             v_sync,
    output logic             vga_clk,
    output logic             frame_start
);

    localparam int unsigned WIN_W = IMG_W * SCALE;
    localparam int unsigned WIN_H = IMG_H * SCALE;
    localparam int unsigned IX_W  = $clog2(IMG_W + 1);
    localparam int unsigned SX_W  = 4;

    logic             phase;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             hsync_raw;
    logic             vsync_raw;
    logic             visible;
    logic [31:0]      h32;
    logic [31:0]      v32;

    vga_timing #(
        .T_H_VISIBLE  (T_H_VISIBLE),
        .T_H_FP_END   (T_H_FP_END),
        .T_H_SYNC_END (T_H_SYNC_END),
        .T_H_TOTAL    (T_H_TOTAL),
        .T_V_VISIBLE  (T_V_VISIBLE),
        .T_V_FP_END   (T_V_FP_END),
        .T_V_SYNC_END (T_V_SYNC_END),
        .T_V_TOTAL    (T_V_TOTAL)
    ) u_timing (
        .clk           (clk),
        .rst_n         (rst),
        .phase_o       (phase),
        .vga_clk_o     (vga_clk),
        .h_o           (h),
        .v_o           (v),
        .hsync_raw_o   (hsync_raw),
        .vsync_raw_o   (vsync_raw),
        .visible_o     (visible),
        .frame_start_o (frame_start)
    );

    logic             en_frame_q, en_frame_d;
    logic [S-1:0]     row_base_q, row_base_d;
    logic [SX_W-1:0]  sy_q, sy_d;
    logic [SX_W-1:0]  sx_q, sx_d;
    logic [IX_W-1:0]  img_x_q, img_x_d;
    logic             rd_en_q, rd_en_d;
    logic [S-1:0]     rd_addr_q, rd_addr_d;
    logic             rd_vld_q, rd_vld_d;
    logic [PIX_W-1:0] rgb_q, rgb_d;
    logic             hs1_q, hs1_d, vs1_q, vs1_d;
    logic             h_sync_q, h_sync_d, v_sync_q, v_sync_d;

    logic             fs_c, in_x_c, in_y_c, line_end_c, read_c, en_now_c, sx_wrap_c;
    logic [S-1:0]     row_base_c;
    logic [SX_W-1:0]  sy_c, sx_c;
    logic [IX_W-1:0]  img_x_c;

    assign h32 = 32'(h);
    assign v32 = 32'(v);

    // Current-pixel view of the address counters: frame start and window left edge restart them.
    assign fs_c       = !phase && (h == '0) && (v == '0);
    assign in_x_c     = (h32 >= X0) && (h32 < X0 + WIN_W);
    assign in_y_c     = (v32 >= Y0) && (v32 < Y0 + WIN_H);
    assign line_end_c = in_y_c && (h32 == X0 + WIN_W - 1);
    assign en_now_c   = fs_c ? enable : en_frame_q;
    assign row_base_c = fs_c ? '0 : row_base_q;
    assign sy_c       = fs_c ? '0 : sy_q;
    assign sx_c       = (h32 == X0) ? '0 : sx_q;
    assign img_x_c    = (h32 == X0) ? '0 : img_x_q;
    assign sx_wrap_c  = (sx_c == SX_W'(SCALE - 1));
    assign read_c     = in_x_c && in_y_c && visible && en_now_c;

    always_comb begin
        en_frame_d = en_frame_q;
        row_base_d = row_base_q;
        sy_d       = sy_q;
        sx_d       = sx_q;
        img_x_d    = img_x_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_vld_d   = rd_vld_q;
        rgb_d      = rgb_q;
        hs1_d      = hs1_q;
        vs1_d      = vs1_q;
        h_sync_d   = h_sync_q;
        v_sync_d   = v_sync_q;
        if (!phase) begin
            en_frame_d = en_now_c;
            row_base_d = row_base_c;
            sy_d       = sy_c;
            if (in_x_c) begin
                sx_d    = sx_wrap_c ? '0 : sx_c + SX_W'(1);
                img_x_d = img_x_c + IX_W'(sx_wrap_c);
            end
            if (line_end_c) begin
                if (sy_c == SX_W'(SCALE - 1)) begin
                    sy_d       = '0;
                    row_base_d = row_base_c + S'(IMG_W);
                end else begin
                    sy_d = sy_c + SX_W'(1);
                end
            end
            if (read_c) begin
                rd_en_d   = 1'b1;
                rd_addr_d = S'(BASE) + row_base_c + S'(img_x_c);
            end
            // Second stage of the two-clk pipeline shared by rgb and the syncs.
            rgb_d    = rd_vld_q ? rd_data : '0;
            hs1_d    = hsync_raw;
            vs1_d    = vsync_raw;
            h_sync_d = hs1_q;
            v_sync_d = vs1_q;
        end else begin
            rd_vld_d = rd_en_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_frame_q <= 1'b0;
            row_base_q <= '0;
            sy_q       <= '0;
            sx_q       <= '0;
            img_x_q    <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_vld_q   <= 1'b0;
            rgb_q      <= '0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            h_sync_q   <= 1'b1;
            v_sync_q   <= 1'b1;
        end else begin
            en_frame_q <= en_frame_d;
            row_base_q <= row_base_d;
            sy_q       <= sy_d;
            sx_q       <= sx_d;
            img_x_q    <= img_x_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            rd_vld_q   <= rd_vld_d;
            rgb_q      <= rgb_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            h_sync_q   <= h_sync_d;
            v_sync_q   <= v_sync_d;
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign rgb     = rgb_q;
    assign h_sync  = h_sync_q;
    assign v_sync  = v_sync_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader on a shrunken 52x36 raster with a 4x3 image scaled by 2.
module tb_vga_frame_reader;

    localparam int HT    = 52;
    localparam int VT    = 36;
    localparam int FRAME = 2 * HT * VT;
    localparam int IMG_W = 4;
    localparam int IMG_H = 3;
    localparam int SCALE = 2;
    localparam int X0    = 6;
    localparam int Y0    = 5;
    localparam int BASE  = 16;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [23:0] rd_data;
    logic [23:0] rgb;
    logic        h_sync;
    logic        v_sync;
    logic        vga_clk;
    logic        frame_start;

    vga_frame_reader #(
        .S(32), .PIX_W(24), .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE(SCALE),
        .X0(X0), .Y0(Y0), .BASE(BASE),
        .T_H_VISIBLE(40), .T_H_FP_END(44), .T_H_SYNC_END(48), .T_H_TOTAL(HT),
        .T_V_VISIBLE(30), .T_V_FP_END(32), .T_V_SYNC_END(34), .T_V_TOTAL(VT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rgb         (rgb),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .vga_clk     (vga_clk),
        .frame_start (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory returns its own address one clk after the strobe, junk otherwise.
    initial rd_data = 24'h0;
    always @(posedge clk) rd_data <= rd_en ? rd_addr[23:0] : 24'hA5A5A5;

    // Edges seen since reset release; edge k = ecnt-1 at the following negedge.
    int ecnt = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) ecnt <= 0;
        else      ecnt <= ecnt + 1;
    end

    typedef struct { int k; int val; } exp_t;
    exp_t exp_rd[$];
    exp_t exp_px[$];

    int checks = 0;
    int errors = 0;
    int vclk_bad = 0, fs_bad = 0, hs_bad = 0, vs_bad = 0, stab_bad = 0;
    int fs_seen = 0, hs_lo0 = 0, vs_lo0 = 0;
    bit first_run = 1'b1;
    logic [23:0] rgb_prev = 24'h0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic push_frame(input int f, input int vmax);
        exp_t t;
        for (int v = Y0; v < Y0 + IMG_H * SCALE; v++) begin
            if (v <= vmax) begin
                for (int h = X0; h < X0 + IMG_W * SCALE; h++) begin
                    t.k   = f * FRAME + 2 * (v * HT + h);
                    t.val = BASE + ((v - Y0) / SCALE) * IMG_W + (h - X0) / SCALE;
                    exp_rd.push_back(t);
                    t.k = t.k + 2;
                    exp_px.push_back(t);
                end
            end
        end
    endtask

    task automatic wait_k(input int k);
        int n;
        n = 0;
        while (ecnt != k + 1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout: got edge %0d want edge %0d", ecnt - 1, k);
        end
    endtask

    task automatic chk_reset();
        chk("rst_rgb", rgb, 0);
        chk("rst_h_sync", h_sync, 1);
        chk("rst_v_sync", v_sync, 1);
        chk("rst_vga_clk", vga_clk, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_frame_start", frame_start, 0);
    endtask

    // Monitor: pops expected reads/pixels as the DUT presents them and tallies per-clk timing.
    int mk, ke, mp, ph, pv;
    logic ehs, evs, efs;
    exp_t e;
    always @(negedge clk) begin
        if (rst && ecnt > 0) begin
            mk = ecnt - 1;
            ke = mk - (mk % 2);
            mp = ke / 2 - 1;
            if (mp < 0) begin
                ehs = 1'b1;
                evs = 1'b1;
            end else begin
                ph  = mp % HT;
                pv  = (mp / HT) % VT;
                ehs = !(ph >= 44 && ph < 48);
                evs = !(pv >= 32 && pv < 34);
            end
            efs = (mk % FRAME) == 0;
            if (vga_clk !== ((mk % 2) == 1)) vclk_bad++;
            if (frame_start !== efs) fs_bad++;
            if (frame_start === 1'b1) fs_seen++;
            if (h_sync !== ehs) hs_bad++;
            if (v_sync !== evs) vs_bad++;
            if (first_run && mk < FRAME && h_sync === 1'b0) hs_lo0++;
            if (first_run && mk < FRAME && v_sync === 1'b0) vs_lo0++;

            while (exp_rd.size() > 0 && exp_rd[0].k < mk) begin
                e = exp_rd.pop_front();
                checks++;
                errors++;
                $display("FAIL rd_missing edge %0d: got no read want addr %0d", e.k, e.val);
            end
            if (rd_en === 1'b1) begin
                checks++;
                if (exp_rd.size() > 0 && exp_rd[0].k == mk) begin
                    e = exp_rd.pop_front();
                    if (rd_addr !== 32'(e.val)) begin
                        errors++;
                        $display("FAIL rd_addr edge %0d: got %0d want %0d", mk, rd_addr, e.val);
                    end
                end else begin
                    errors++;
                    $display("FAIL rd_unexpected edge %0d: got addr %0d want no read", mk, rd_addr);
                end
            end

            if (mk % 2 == 0) begin
                while (exp_px.size() > 0 && exp_px[0].k < mk) begin
                    e = exp_px.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL rgb_missing edge %0d: got black want %0d", e.k, e.val);
                end
                if (rgb !== 24'h0) begin
                    checks++;
                    if (exp_px.size() > 0 && exp_px[0].k == mk) begin
                        e = exp_px.pop_front();
                        if (rgb !== 24'(e.val)) begin
                            errors++;
                            $display("FAIL rgb edge %0d: got %0d want %0d", mk, rgb, e.val);
                        end
                    end else begin
                        errors++;
                        $display("FAIL rgb_unexpected edge %0d: got %0d want 0", mk, rgb);
                    end
                end
            end else if (rgb !== rgb_prev) begin
                stab_bad++;
            end
        end
        rgb_prev = rgb;
    end

    // Hand-computed read points in frame 1: screen (h,v) -> expected strobe and address.
    int a_h [0:7] = '{6, 7, 8, 13, 14, 6, 6, 11};
    int a_v [0:7] = '{5, 5, 5, 5, 5, 6, 7, 7};
    int a_e [0:7] = '{1, 1, 1, 1, 0, 1, 1, 1};
    int a_a [0:7] = '{16, 16, 17, 19, 0, 16, 20, 22};

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset();
        rst = 1'b1;

        // Raising enable mid frame 0 must not start reads before frame 1.
        wait_k(100);
        enable = 1'b1;
        push_frame(1, 99);

        for (int i = 0; i < 8; i++) begin
            wait_k(FRAME + 2 * (a_v[i] * HT + a_h[i]));
            chk($sformatf("anchor_rd_en_%0d_%0d", a_h[i], a_v[i]), rd_en, a_e[i]);
            if (a_e[i] == 1) chk($sformatf("anchor_rd_addr_%0d_%0d", a_h[i], a_v[i]), rd_addr, a_a[i]);
        end

        // Dropping enable at line 8 lets frame 1 finish; frame 2 stays black.
        wait_k(FRAME + 2 * (8 * HT));
        enable = 1'b0;
        wait_k(FRAME + 2 * (10 * HT + 13));
        chk("last_rd_en", rd_en, 1);
        chk("last_rd_addr", rd_addr, 27);
        wait_k(FRAME + 2 * (10 * HT + 13) + 2);
        chk("last_rgb", rgb, 27);
        wait_k(FRAME + 2 * (10 * HT + 14));
        chk("after_window_rd_en", rd_en, 0);

        wait_k(2 * FRAME + 200);
        enable = 1'b1;
        push_frame(3, 7);

        // Reset at (30,7) of frame 3, held for 3 clks.
        wait_k(3 * FRAME + 2 * (7 * HT + 30));
        rst       = 1'b0;
        first_run = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_reset();
        end
        rst = 1'b1;
        push_frame(0, 99);
        wait_k(0);
        chk("frame_start_after_reset", frame_start, 1);
        wait_k(FRAME + 100);

        chk("vga_clk_bad_clks", vclk_bad, 0);
        chk("frame_start_bad_clks", fs_bad, 0);
        chk("frame_start_pulses", fs_seen, 6);
        chk("h_sync_bad_clks", hs_bad, 0);
        chk("v_sync_bad_clks", vs_bad, 0);
        chk("h_sync_low_clks_frame0", hs_lo0, 288);
        chk("v_sync_low_clks_frame0", vs_lo0, 208);
        chk("rgb_unstable_clks", stab_bad, 0);
        chk("reads_left", exp_rd.size(), 0);
        chk("pixels_left", exp_px.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
